// File: rtl/groove_sweep_sequencer.sv
// rtl/groove_sweep_sequencer.sv - sweep-end sync qualifier, direction tracker and lock FSM for the groove sample selector
module groove_sweep_sequencer #(
    parameter int unsigned MIN_PERIOD     = 2000,
    parameter int unsigned MAX_PERIOD     = 200000,
    parameter int unsigned HOLDOFF_CYCLES = 64,
    parameter int unsigned TIMEOUT_CYCLES = 400000,
    parameter int unsigned LOCK_COUNT     = 4,
    parameter int unsigned MISS_LIMIT     = 3
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        enable,
    input  logic [31:0] current_timestamp,
    input  logic        lsync_pulse,
    input  logic        rsync_pulse,
    input  logic        best_sample_valid,
    output logic        dir,
    output logic        sync_pulse,
    output logic [31:0] sweep_period,
    output logic        locked,
    output logic        sweep_timeout,
    output logic        dir_error
);

    typedef enum logic [1:0] {
        S_IDLE    = 2'd0,
        S_SEARCH  = 2'd1,
        S_ACQUIRE = 2'd2,
        S_LOCKED  = 2'd3
    } state_t;

    localparam logic [31:0] MIN_P        = 32'(MIN_PERIOD);
    localparam logic [31:0] MAX_P        = 32'(MAX_PERIOD);
    localparam logic [15:0] HOLDOFF_INIT = 16'(HOLDOFF_CYCLES);
    // The watchdog reads 0 in the cycle after an accept, and expiry is decided one
    // cycle ahead so the registered pulse lands exactly TIMEOUT_CYCLES after the sync.
    localparam logic [31:0] WD_FIRE      = 32'(TIMEOUT_CYCLES - 2);
    localparam logic [4:0]  LOCK_TGT     = 5'(LOCK_COUNT);
    localparam logic [4:0]  MISS_TGT     = 5'(MISS_LIMIT);

    state_t      state;
    state_t      state_next;

    logic [15:0] holdoff_cnt;
    logic [31:0] watchdog;
    logic [31:0] last_sync_time;
    logic [3:0]  good_cnt;
    logic [3:0]  miss_cnt;
    logic        flip_pending;
    logic        chk_stage1;
    logic        chk_stage2;
    logic        chk_bad1;
    logic        chk_bad2;

    logic        active;
    logic        timeout_hit;
    logic        sync_accept;
    logic        both_err;
    logic        src_dir;
    logic [31:0] period;
    logic        period_ok;
    logic        src_match;
    logic        good_sweep;
    logic        lock_reached;
    logic        miss_reached;
    logic        locked_eval;
    logic        miss_now;

    logic        dir_next;
    logic        sync_pulse_next;
    logic [31:0] sweep_period_next;
    logic        locked_next;
    logic        sweep_timeout_next;
    logic        dir_error_next;

    assign active       = enable && (state != S_IDLE);
    assign timeout_hit  = active && (watchdog >= WD_FIRE);
    assign src_dir      = rsync_pulse;
    assign sync_accept  = active && !timeout_hit && (lsync_pulse ^ rsync_pulse)
                          && (holdoff_cnt == 16'd0);
    assign both_err     = active && !timeout_hit && lsync_pulse && rsync_pulse
                          && (holdoff_cnt == 16'd0);
    assign period       = current_timestamp - last_sync_time;
    assign period_ok    = (period >= MIN_P) && (period <= MAX_P);
    assign src_match    = (src_dir == dir);
    assign good_sweep   = period_ok && src_match;
    assign lock_reached = ({1'b0, good_cnt} + 5'd1) >= LOCK_TGT;
    assign miss_reached = ({1'b0, miss_cnt} + 5'd1) >= MISS_TGT;
    // A LOCKED sweep is judged two cycles after its sync, when the selector result arrives.
    assign locked_eval  = chk_stage2 && (state == S_LOCKED);
    assign miss_now     = chk_bad2 || !best_sample_valid;

    // State register.
    always_ff @(posedge clk) begin
        if (reset) begin
            state <= S_IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next-state: enable and watchdog expiry override the per-state transitions.
    always_comb begin
        state_next = state;
        if (!enable) begin
            state_next = S_IDLE;
        end else if (timeout_hit) begin
            state_next = S_SEARCH;
        end else begin
            case (state)
                S_IDLE:    state_next = S_SEARCH;
                S_SEARCH:  if (sync_accept) state_next = S_ACQUIRE;
                S_ACQUIRE: if (sync_accept && good_sweep && lock_reached) state_next = S_LOCKED;
                S_LOCKED:  if (locked_eval && miss_now && miss_reached) state_next = S_SEARCH;
                default:   state_next = S_IDLE;
            endcase
        end
    end

    // Output next-values: everything leaving the block is registered.
    always_comb begin
        sync_pulse_next    = sync_accept;
        sweep_period_next  = sweep_period;
        if (sync_accept) begin
            sweep_period_next = period;
        end
        locked_next        = (state_next == S_LOCKED);
        sweep_timeout_next = timeout_hit;
        dir_error_next     = both_err
                             || (sync_accept && !src_match
                                 && ((state == S_ACQUIRE) || (state == S_LOCKED)));
        dir_next           = dir;
        if (sync_accept) begin
            dir_next = src_dir;
        end else if (flip_pending) begin
            dir_next = ~dir;
        end
    end

    // Output registers.
    always_ff @(posedge clk) begin
        if (reset) begin
            dir           <= 1'b0;
            sync_pulse    <= 1'b0;
            sweep_period  <= 32'd0;
            locked        <= 1'b0;
            sweep_timeout <= 1'b0;
            dir_error     <= 1'b0;
        end else begin
            dir           <= dir_next;
            sync_pulse    <= sync_pulse_next;
            sweep_period  <= sweep_period_next;
            locked        <= locked_next;
            sweep_timeout <= sweep_timeout_next;
            dir_error     <= dir_error_next;
        end
    end

    // Sync timing: last accepted timestamp, holdoff window, watchdog and direction flip.
    always_ff @(posedge clk) begin
        if (reset) begin
            last_sync_time <= 32'd0;
            holdoff_cnt    <= 16'd0;
            watchdog       <= 32'd0;
            flip_pending   <= 1'b0;
        end else begin
            flip_pending <= sync_accept;
            if (sync_accept) begin
                last_sync_time <= current_timestamp;
            end
            if (sync_accept) begin
                holdoff_cnt <= HOLDOFF_INIT;
            end else if (holdoff_cnt != 16'd0) begin
                holdoff_cnt <= holdoff_cnt - 16'd1;
            end
            if (!active || sync_accept || timeout_hit) begin
                watchdog <= 32'd0;
            end else if (watchdog != 32'hFFFF_FFFF) begin
                watchdog <= watchdog + 32'd1;
            end
        end
    end

    // Lock bookkeeping: good-sweep count in ACQUIRE, miss pipeline and count in LOCKED.
    always_ff @(posedge clk) begin
        if (reset) begin
            good_cnt   <= 4'd0;
            miss_cnt   <= 4'd0;
            chk_stage1 <= 1'b0;
            chk_stage2 <= 1'b0;
            chk_bad1   <= 1'b0;
            chk_bad2   <= 1'b0;
        end else begin
            chk_stage1 <= sync_accept && (state == S_LOCKED) && (state_next == S_LOCKED);
            chk_bad1   <= !good_sweep;
            chk_stage2 <= chk_stage1;
            chk_bad2   <= chk_bad1;

            if (state_next != S_ACQUIRE) begin
                good_cnt <= 4'd0;
            end else if (sync_accept) begin
                if ((state == S_ACQUIRE) && good_sweep) begin
                    good_cnt <= good_cnt + 4'd1;
                end else begin
                    good_cnt <= 4'd0;
                end
            end

            if (state_next != S_LOCKED) begin
                miss_cnt <= 4'd0;
            end else if (locked_eval) begin
                if (miss_now) begin
                    miss_cnt <= miss_cnt + 4'd1;
                end else begin
                    miss_cnt <= 4'd0;
                end
            end
        end
    end

endmodule
